load_control: RTL and testbench

LOAD_CONTROL -- requirements
Module: load_control

---
 rtl/load_pkg.sv | 58 +++++
 rtl/load_fmt.sv | 41 ++++
 rtl/load_control.sv | 163 ++++++++++++++++
 tb/tb_load_control.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
// Shared definitions for the load control path: funct3 codes, address
// region encoding, FSM state encoding, latched request payload, and small
// decode helpers.
// Optional feature macro used by importers: LOAD_MISALIGN_TRAP_EN.
package load_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 5;

  // RISC-V load funct3 codes
  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;

  typedef enum logic [1:0] {
    REG_UNMAPPED = 2'd0,
    REG_DMEM     = 2'd1,
    REG_BIOS     = 2'd2,
    REG_IO       = 2'd3
  } region_e;

  // FSM state encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_IO   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Request fields captured when a load is accepted
  typedef struct packed {
    logic [2:0]        fnc;
    logic [1:0]        off;
    region_e           region;
    logic [RD_W-1:0]   rd;
    logic [ADDR_W-1:0] addr;
  } ld_info_t;

  // Priority decode: IO over BIOS over DMEM
  function automatic region_e decode_region(input logic [ADDR_W-1:0] addr);
    if (addr[31])      return REG_IO;
    else if (addr[30]) return REG_BIOS;
    else if (addr[28]) return REG_DMEM;
    else               return REG_UNMAPPED;
  endfunction

  // funct3 values that are not valid loads
  function automatic logic fnc_bad(input logic [2:0] fnc);
    return (fnc == 3'b011) || (fnc[2:1] == 2'b11);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] fnc, input logic [1:0] off);
    return (((fnc == F_LH) || (fnc == F_LHU)) && off[0]) ||
           ((fnc == F_LW) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_fmt.sv
// Combinational load data formatter: selects byte/half/word from a memory
// word by funct3 and low address bits, then sign- or zero-extends.
// Ports: fnc (funct3), off (addr[1:0]), word (raw read word),
//        data (formatted result, 0 for invalid funct3).
module load_fmt
  import load_pkg::*;
(
  input  logic [2:0]        fnc,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Lane select; halfword ignores off[0]
  always_comb begin
    byte_c = word[7:0];
    case (off)
      2'd0:    byte_c = word[7:0];
      2'd1:    byte_c = word[15:8];
      2'd2:    byte_c = word[23:16];
      default: byte_c = word[31:24];
    endcase
    half_c = off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = '0;
    case (fnc)
      F_LB:    data = {{24{byte_c[7]}}, byte_c};
      F_LBU:   data = {24'd0, byte_c};
      F_LH:    data = {{16{half_c[15]}}, half_c};
      F_LHU:   data = {16'd0, half_c};
      F_LW:    data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_control.sv
// Load unit control: decodes the load region, returns DMEM/BIOS data one
// cycle after issue (back-to-back capable), and runs a stalling MMIO read
// handshake with timeout for IO-region loads.
// Ports: clk, rst_n (async active-low); ld_req/ld_fnc/ld_addr/ld_rd issue a
//        load; dmem_rdata/bios_rdata are 1-cycle synchronous read words;
//        io_req/io_addr/io_rdata/io_rvalid form the MMIO read handshake;
//        ld_valid/ld_data/ld_rd_out/ld_err carry the writeback result;
//        stall holds core issue during MMIO reads.
// Parameter: IO_TIMEOUT, maximum IO-state cycles waiting for io_rvalid.
// Macro: LOAD_MISALIGN_TRAP_EN turns misaligned LH/LHU/LW into errors.
module load_control
  import load_pkg::*;
#(
  parameter int unsigned IO_TIMEOUT = 255
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_req,
  input  logic [2:0]        ld_fnc,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [RD_W-1:0]   ld_rd,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [DATA_W-1:0] bios_rdata,
  output logic              io_req,
  output logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic              io_rvalid,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic [RD_W-1:0]   ld_rd_out,
  output logic              ld_err,
  output logic              stall
);

  localparam int unsigned CNT_W = $clog2(IO_TIMEOUT + 1);

  logic [1:0]        state_q, state_d;
  ld_info_t          info_q, info_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] capt_q, capt_d;
  logic              terr_q, terr_d;

  logic              mis_c;
  region_e           region_c;
  logic [DATA_W-1:0] word_c;
  logic [DATA_W-1:0] fmt_c;

`ifdef LOAD_MISALIGN_TRAP_EN
  assign mis_c = is_misaligned(ld_fnc, ld_addr[1:0]);
`else
  assign mis_c = 1'b0;
`endif

  // Misaligned loads complete in MEM as an error, same as unmapped
  assign region_c = mis_c ? REG_UNMAPPED : decode_region(ld_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      info_q  <= '0;
      cnt_q   <= '0;
      capt_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      info_q  <= info_d;
      cnt_q   <= cnt_d;
      capt_q  <= capt_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state and latch update
  always_comb begin
    state_d = state_q;
    info_d  = info_q;
    cnt_d   = cnt_q;
    capt_d  = capt_q;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE, S_MEM: begin
        state_d = S_IDLE;
        if (ld_req) begin
          info_d.fnc    = ld_fnc;
          info_d.off    = ld_addr[1:0];
          info_d.region = region_c;
          info_d.rd     = ld_rd;
          info_d.addr   = ld_addr;
          cnt_d         = '0;
          capt_d        = '0;
          terr_d        = 1'b0;
          state_d       = (region_c == REG_IO) ? S_IO : S_MEM;
        end
      end
      S_IO: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Data wins over a coincident timeout
        if (io_rvalid) begin
          capt_d  = io_rdata;
          terr_d  = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(IO_TIMEOUT - 1)) begin
          capt_d  = '0;
          terr_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign word_c = (state_q == S_DONE)            ? capt_q     :
                  (info_q.region == REG_BIOS)    ? bios_rdata : dmem_rdata;

  load_fmt u_fmt (
    .fnc  (info_q.fnc),
    .off  (info_q.off),
    .word (word_c),
    .data (fmt_c)
  );

  // Result, handshake and stall outputs
  always_comb begin
    ld_valid  = 1'b0;
    ld_data   = '0;
    ld_err    = 1'b0;
    ld_rd_out = '0;
    io_req    = 1'b0;
    io_addr   = '0;
    stall     = 1'b0;
    case (state_q)
      S_MEM: begin
        ld_valid  = 1'b1;
        ld_rd_out = info_q.rd;
        if (info_q.region == REG_UNMAPPED) begin
          ld_err = 1'b1;
        end else begin
          ld_data = fmt_c;
          ld_err  = fnc_bad(info_q.fnc);
        end
      end
      S_IO: begin
        stall = 1'b1;
        // Counter is zero only on the first IO cycle
        if (cnt_q == '0) begin
          io_req  = 1'b1;
          io_addr = info_q.addr;
        end
      end
      S_DONE: begin
        stall     = 1'b1;
        ld_valid  = 1'b1;
        ld_rd_out = info_q.rd;
        ld_data   = terr_q ? '0 : fmt_c;
        ld_err    = terr_q | fnc_bad(info_q.fnc);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_control.sv
module tb_load_control;

  logic        clk;
  logic        rst_n;
  logic        ld_req;
  logic [2:0]  ld_fnc;
  logic [31:0] ld_addr;
  logic [4:0]  ld_rd;
  logic [31:0] dmem_rdata;
  logic [31:0] bios_rdata;
  logic        io_req;
  logic [31:0] io_addr;
  logic [31:0] io_rdata;
  logic        io_rvalid;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [4:0]  ld_rd_out;
  logic        ld_err;
  logic        stall;

  int n_tests = 0;
  int n_fail  = 0;

  load_control #(.IO_TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_req     (ld_req),
    .ld_fnc     (ld_fnc),
    .ld_addr    (ld_addr),
    .ld_rd      (ld_rd),
    .dmem_rdata (dmem_rdata),
    .bios_rdata (bios_rdata),
    .io_req     (io_req),
    .io_addr    (io_addr),
    .io_rdata   (io_rdata),
    .io_rvalid  (io_rvalid),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_rd_out  (ld_rd_out),
    .ld_err     (ld_err),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [4:0] r);
    ld_req  = 1'b1;
    ld_fnc  = f;
    ld_addr = a;
    ld_rd   = r;
  endtask

  // Single-cycle DMEM load returning in MEM, checked against hand values
  task automatic dmem_load(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] word, input logic [31:0] exp_d, input logic exp_e);
    issue(f, a, 5'd12);
    cyc();
    ld_req = 1'b0;
    dmem_rdata = word;
    #1;
    chk({tag, "_valid"}, 32'(ld_valid), 32'd1);
    chk({tag, "_data"}, ld_data, exp_d);
    chk({tag, "_err"}, 32'(ld_err), 32'(exp_e));
    cyc();
  endtask

  int stall_cnt;
  int ioreq_cnt;

  initial begin
    rst_n = 1'b0; ld_req = 1'b0; ld_fnc = 3'd0; ld_addr = '0; ld_rd = '0;
    dmem_rdata = '0; bios_rdata = '0; io_rdata = '0; io_rvalid = 1'b0;
    #3;
    chk("rst_valid", 32'(ld_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ioreq", 32'(io_req), 32'd0);
    chk("rst_err", 32'(ld_err), 32'd0);
    chk("rst_data", ld_data, 32'd0);
    chk("rst_ioaddr", io_addr, 32'd0);
    chk("rst_rd", 32'(ld_rd_out), 32'd0);
    #9 rst_n = 1'b1;
    cyc();

    // LB at DMEM byte 3, sign-extended
    issue(3'b000, 32'h1000_0003, 5'd5);
    cyc();
    ld_req = 1'b0;
    dmem_rdata = 32'h80FF_1234;
    #1;
    chk("lb_valid", 32'(ld_valid), 32'd1);
    chk("lb_data", ld_data, 32'hFFFF_FF80);
    chk("lb_stall", 32'(stall), 32'd0);
    chk("lb_err", 32'(ld_err), 32'd0);
    chk("lb_rd", 32'(ld_rd_out), 32'd5);
    cyc();
    chk("idle_valid", 32'(ld_valid), 32'd0);
    chk("idle_data", ld_data, 32'd0);

    // LHU at BIOS upper half, then back-to-back LW
    issue(3'b101, 32'h4000_0002, 5'd7);
    cyc();
    bios_rdata = 32'h8001_ABCD;
    issue(3'b010, 32'h4000_0000, 5'd8);
    #1;
    chk("lhu_valid", 32'(ld_valid), 32'd1);
    chk("lhu_data", ld_data, 32'h0000_8001);
    chk("lhu_rd", 32'(ld_rd_out), 32'd7);
    cyc();
    ld_req = 1'b0;
    bios_rdata = 32'hCAFE_F00D;
    #1;
    chk("b2b_valid", 32'(ld_valid), 32'd1);
    chk("b2b_data", ld_data, 32'hCAFE_F00D);
    chk("b2b_rd", 32'(ld_rd_out), 32'd8);
    cyc();
    chk("b2b_idle", 32'(ld_valid), 32'd0);

    // Other formats (low address bits honoured / ignored)
    dmem_load("lh", 3'b001, 32'h1000_0001, 32'h1234_8765, 32'hFFFF_8765, 1'b0);
    dmem_load("lbu", 3'b100, 32'h1000_0002, 32'h00A5_0000, 32'h0000_00A5, 1'b0);
    dmem_load("lw_off", 3'b010, 32'h1000_0003, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
    // Unmapped region and invalid funct3
    dmem_load("unmap", 3'b010, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0, 1'b1);
    dmem_load("fnc7", 3'b111, 32'h1000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);

    // io_rvalid while idle has no effect
    io_rvalid = 1'b1; io_rdata = 32'h5555_5555;
    #1;
    chk("rv_idle_valid", 32'(ld_valid), 32'd0);
    cyc();
    chk("rv_idle_valid2", 32'(ld_valid), 32'd0);
    io_rvalid = 1'b0;

    // IO LW, response 5 cycles after io_req; stray ld_req during IO ignored
    issue(3'b010, 32'h8000_0010, 5'd3);
    #1;
    chk("io_pre_stall", 32'(stall), 32'd0);
    stall_cnt = 0;
    ioreq_cnt = 0;
    cyc();
    ld_req = 1'b0;
    chk("io_addr", io_addr, 32'h8000_0010);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) issue(3'b010, 32'h1000_0000, 5'd9);
      if (k == 5) begin io_rvalid = 1'b1; io_rdata = 32'h1234_5678; end
      #1;
      if (stall) stall_cnt++;
      if (io_req) ioreq_cnt++;
      chk("io_wait_valid", 32'(ld_valid), 32'd0);
      cyc();
      ld_req = 1'b0;
    end
    io_rvalid = 1'b0;
    if (stall) stall_cnt++;
    chk("io_done_valid", 32'(ld_valid), 32'd1);
    chk("io_done_data", ld_data, 32'h1234_5678);
    chk("io_done_err", 32'(ld_err), 32'd0);
    chk("io_done_rd", 32'(ld_rd_out), 32'd3);
    cyc();
    chk("io_stall_cycles", 32'(stall_cnt), 32'd7);
    chk("io_req_pulses", 32'(ioreq_cnt), 32'd1);
    chk("io_after_stall", 32'(stall), 32'd0);
    chk("io_after_valid", 32'(ld_valid), 32'd0);

    // Timeout: 8 IO cycles without response
    issue(3'b010, 32'h8000_0020, 5'd4);
    cyc();
    ld_req = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("to_wait_valid", 32'(ld_valid), 32'd0);
    end
    cyc();
    chk("to_valid", 32'(ld_valid), 32'd1);
    chk("to_err", 32'(ld_err), 32'd1);
    chk("to_data", ld_data, 32'd0);
    chk("to_stall", 32'(stall), 32'd1);
    cyc();

    // Response on the timeout cycle: data wins
    issue(3'b010, 32'h8000_0024, 5'd6);
    cyc();
    ld_req = 1'b0;
    for (int k = 0; k < 7; k++) cyc();
    io_rvalid = 1'b1; io_rdata = 32'hDEAD_BEEF;
    cyc();
    io_rvalid = 1'b0;
    chk("tie_valid", 32'(ld_valid), 32'd1);
    chk("tie_err", 32'(ld_err), 32'd0);
    chk("tie_data", ld_data, 32'hDEAD_BEEF);
    cyc();

    // Reset during IO wait abandons the read
    issue(3'b010, 32'h8000_0030, 5'd2);
    cyc();
    ld_req = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("rstio_stall", 32'(stall), 32'd0);
    chk("rstio_valid", 32'(ld_valid), 32'd0);
    chk("rstio_ioreq", 32'(io_req), 32'd0);
    rst_n = 1'b1;
    cyc();
    io_rvalid = 1'b1; io_rdata = 32'h7777_7777;
    #1;
    chk("rstio_rv_valid", 32'(ld_valid), 32'd0);
    cyc();
    io_rvalid = 1'b0;
    chk("rstio_after_valid", 32'(ld_valid), 32'd0);
    chk("rstio_after_stall", 32'(stall), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
